exmem_line_responder: RTL and testbench

//  Wishbone classic responder modelling the shared external memory behind the

---
 rtl/exmem_line_responder.sv | 207 ++++++++++++++++++++
 tb/tb_exmem_line_responder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/exmem_line_responder.sv
// Wishbone classic responder for the shared external memory window (BASE_HI).
// Every in-window access waits DELAYS cycles, except reads that hit the one-line buffer.
module exmem_line_responder #(
   parameter int         DEPTH_LOG2 = 10,
   parameter int         LINE_LOG2  = 2,
   parameter int         DELAYS     = 10,
   parameter logic [7:0] BASE_HI    = 8'h38
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_dat_i,
   input  logic [31:0] wbs_adr_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        busy_o,
   output logic [15:0] hit_cnt_o,
   output logic [15:0] miss_cnt_o
);

   localparam int DEPTH      = 1 << DEPTH_LOG2;
   localparam int LINE_WORDS = 1 << LINE_LOG2;
   localparam int TAG_W      = DEPTH_LOG2 - LINE_LOG2;
   localparam int WCNT_W     = (DELAYS > 1) ? $clog2(DELAYS) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_FILL = 2'd2;
   localparam logic [1:0] S_ACK  = 2'd3;

   logic [31:0]           mem_q  [DEPTH];
   logic [31:0]           lbuf_q [LINE_WORDS];

   logic [1:0]            state_q, state_d;
   logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
   logic [LINE_LOG2-1:0]  fcnt_q, fcnt_d;
   logic                  ack_q, ack_d;
   logic [31:0]           dat_q, dat_d;
   logic                  valid_q, valid_d;
   logic [TAG_W-1:0]      tag_q, tag_d;
   logic [15:0]           hit_q, hit_d;
   logic [15:0]           miss_q, miss_d;

   logic                  we_q, we_d;
   logic [DEPTH_LOG2-1:0] widx_q, widx_d;
   logic [3:0]            sel_q, sel_d;
   logic [31:0]           wdat_q, wdat_d;

   logic                  mem_we, buf_we, fill_we;
   logic                  req_live, in_win;
   logic [DEPTH_LOG2-1:0] in_widx;
   logic [TAG_W-1:0]      in_tag, req_tag;
   logic [LINE_LOG2-1:0]  in_off, req_off;
   logic                  unused_adr;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  sel);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++)
         if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   assign req_live   = wbs_stb_i & wbs_cyc_i;
   assign in_win     = (wbs_adr_i[31:24] == BASE_HI);
   assign in_widx    = wbs_adr_i[DEPTH_LOG2+1:2];
   assign in_tag     = in_widx[DEPTH_LOG2-1:LINE_LOG2];
   assign in_off     = in_widx[LINE_LOG2-1:0];
   assign req_tag    = widx_q[DEPTH_LOG2-1:LINE_LOG2];
   assign req_off    = widx_q[LINE_LOG2-1:0];
   assign unused_adr = ^{wbs_adr_i[23:DEPTH_LOG2+2], wbs_adr_i[1:0]};

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      fcnt_d  = fcnt_q;
      ack_d   = 1'b0;
      dat_d   = 32'd0;
      valid_d = valid_q;
      tag_d   = tag_q;
      hit_d   = hit_q;
      miss_d  = miss_q;
      we_d    = we_q;
      widx_d  = widx_q;
      sel_d   = sel_q;
      wdat_d  = wdat_q;
      mem_we  = 1'b0;
      buf_we  = 1'b0;
      fill_we = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_live) begin
               we_d   = wbs_we_i;
               widx_d = in_widx;
               sel_d  = wbs_sel_i;
               wdat_d = wbs_dat_i;
               if (!in_win) begin
                  state_d = S_ACK;
                  ack_d   = 1'b1;
               end else if (!wbs_we_i && valid_q && (tag_q == in_tag)) begin
                  state_d = S_ACK;
                  ack_d   = 1'b1;
                  dat_d   = lbuf_q[in_off];
                  hit_d   = sat_inc(hit_q);
               end else begin
                  state_d = S_WAIT;
                  wcnt_d  = WCNT_W'(DELAYS - 1);
               end
            end
         end
         S_WAIT: begin
            if (!req_live) begin
               state_d = S_IDLE;
            end else if (wcnt_q != '0) begin
               wcnt_d = wcnt_q - 1'b1;
            end else if (we_q) begin
               // Buffer is patched alongside memory so later hits stay coherent.
               state_d = S_ACK;
               ack_d   = 1'b1;
               mem_we  = 1'b1;
               buf_we  = valid_q && (tag_q == req_tag);
            end else begin
               state_d = S_FILL;
               fcnt_d  = '0;
               valid_d = 1'b0;
            end
         end
         S_FILL: begin
            if (!req_live) begin
               state_d = S_IDLE;
               valid_d = 1'b0;
            end else begin
               fill_we = 1'b1;
               if (fcnt_q == LINE_LOG2'(LINE_WORDS - 1)) begin
                  state_d = S_ACK;
                  ack_d   = 1'b1;
                  dat_d   = mem_q[widx_q];
                  valid_d = 1'b1;
                  tag_d   = req_tag;
                  miss_d  = sat_inc(miss_q);
               end else begin
                  fcnt_d = fcnt_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= S_IDLE;
         wcnt_q  <= '0;
         fcnt_q  <= '0;
         ack_q   <= 1'b0;
         dat_q   <= 32'd0;
         valid_q <= 1'b0;
         hit_q   <= 16'd0;
         miss_q  <= 16'd0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         fcnt_q  <= fcnt_d;
         ack_q   <= ack_d;
         dat_q   <= dat_d;
         valid_q <= valid_d;
         hit_q   <= hit_d;
         miss_q  <= miss_d;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      we_q   <= we_d;
      widx_q <= widx_d;
      sel_q  <= sel_d;
      wdat_q <= wdat_d;
      tag_q  <= tag_d;
   end

   // Storage is never cleared; reset only blocks a write landing on its edge.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         if (mem_we)
            mem_q[widx_q] <= lane_merge(mem_q[widx_q], wdat_q, sel_q);
         if (buf_we)
            lbuf_q[req_off] <= lane_merge(lbuf_q[req_off], wdat_q, sel_q);
         if (fill_we)
            lbuf_q[fcnt_q] <= mem_q[{req_tag, fcnt_q}];
      end
   end

   assign wbs_ack_o  = ack_q;
   assign wbs_dat_o  = dat_q;
   assign busy_o     = (state_q != S_IDLE);
   assign hit_cnt_o  = hit_q;
   assign miss_cnt_o = miss_q;

endmodule

// File: tb/tb_exmem_line_responder.sv
// Directed bench for exmem_line_responder with a transaction-level memory/line model
// checked against the DUT every cycle.
module tb_exmem_line_responder;

   localparam int DLY = 10;
   localparam int LW  = 4;

   logic        clk = 1'b0;
   logic        rst, stb, cyc, we;
   logic [3:0]  sel;
   logic [31:0] dat_i, adr;
   logic        ack, busy;
   logic [31:0] dat_o;
   logic [15:0] hit, miss;

   int n_tests = 0;
   int n_fail  = 0;

   bit          chk_en = 1'b0;
   logic        exp_ack, exp_busy;
   logic [31:0] exp_dat;
   logic [15:0] exp_hit, exp_miss;

   logic [31:0] m_mem [0:1023];
   bit          m_valid;
   logic [7:0]  m_tag;
   logic [15:0] m_hit, m_miss;

   int          lat;
   logic [31:0] rd;

   always #5 clk = ~clk;

   exmem_line_responder dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .wbs_stb_i  (stb),
      .wbs_cyc_i  (cyc),
      .wbs_we_i   (we),
      .wbs_sel_i  (sel),
      .wbs_dat_i  (dat_i),
      .wbs_adr_i  (adr),
      .wbs_ack_o  (ack),
      .wbs_dat_o  (dat_o),
      .busy_o     (busy),
      .hit_cnt_o  (hit),
      .miss_cnt_o (miss)
   );

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk32("ack",  32'(ack),  32'(exp_ack));
         chk32("dat",  dat_o,     exp_dat);
         chk32("busy", 32'(busy), 32'(exp_busy));
         chk32("hit",  32'(hit),  32'(exp_hit));
         chk32("miss", 32'(miss), 32'(exp_miss));
      end
   end

   function automatic logic [15:0] sat16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   task automatic exp_idle();
      exp_ack  = 1'b0;
      exp_dat  = 32'd0;
      exp_busy = 1'b0;
      exp_hit  = m_hit;
      exp_miss = m_miss;
   endtask

   // One bus transaction; abort_at / rst_at = cycle (after request) at which cyc drops / reset rises.
   task automatic req(input bit w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                      input int abort_at, input int rst_at,
                      output int ack_cyc, output logic [31:0] ack_dat);
      bit          inwin, is_hit, done;
      int          widx, line, L;
      logic [31:0] rdat;
      inwin  = (a[31:24] == 8'h38);
      widx   = int'(a[11:2]);
      line   = widx / LW;
      is_hit = inwin && !w && m_valid && (m_tag == 8'(line));
      if (!inwin || is_hit) L = 1;
      else if (w)           L = DLY + 1;
      else                  L = DLY + LW + 1;
      rdat    = (!inwin || w) ? 32'd0 : m_mem[widx];
      ack_cyc = -1;
      ack_dat = 32'd0;
      @(posedge clk); #1;
      stb = 1'b1; cyc = 1'b1; we = w; adr = a; sel = s; dat_i = d;
      exp_idle();
      done = 1'b0;
      for (int k = 1; !done; k++) begin
         @(posedge clk); #1;
         if (ack && ack_cyc < 0) begin
            ack_cyc = k;
            ack_dat = dat_o;
         end
         if (rst_at > 0 && k == rst_at + 1) begin
            m_valid = 1'b0; m_hit = 16'd0; m_miss = 16'd0;
            exp_idle();
            rst  = 1'b0;
            done = 1'b1;
         end else if (abort_at > 0 && k == abort_at + 1) begin
            if (inwin && !w && !is_hit && abort_at > DLY) m_valid = 1'b0;
            exp_idle();
            done = 1'b1;
         end else if (k == L) begin
            if (inwin && w) begin
               for (int b = 0; b < 4; b++)
                  if (s[b]) m_mem[widx][8*b +: 8] = d[8*b +: 8];
            end else if (is_hit) begin
               m_hit = sat16(m_hit);
            end else if (inwin) begin
               m_miss  = sat16(m_miss);
               m_valid = 1'b1;
               m_tag   = 8'(line);
            end
            exp_idle();
            exp_ack  = 1'b1;
            exp_dat  = rdat;
            exp_busy = 1'b1;
         end else if (k == L + 1) begin
            exp_idle();
            done = 1'b1;
         end else begin
            exp_idle();
            exp_busy = 1'b1;
         end
         if (k == 1 && L > 1) begin
            adr = a ^ 32'h0000_0FF4; dat_i = ~d; sel = ~s; we = ~w;
         end
         if (k == abort_at) cyc = 1'b0;
         if (k == rst_at) begin
            rst = 1'b1; stb = 1'b0; cyc = 1'b0;
         end
         if (done) begin
            stb = 1'b0; cyc = 1'b0;
         end
      end
   endtask

   initial begin
      rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; dat_i = 32'd0; adr = 32'd0;
      for (int i = 0; i < 1024; i++) m_mem[i] = 32'd0;
      m_valid = 1'b0; m_tag = 8'd0; m_hit = 16'd0; m_miss = 16'd0;
      @(posedge clk); #1;
      exp_idle();
      chk_en = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;

      // Write latency and preload of lines 0, 1 and 4
      req(1'b1, 32'h3800_0000, 4'hF, 32'h1234_5678, 0, 0, lat, rd);
      chk32("t1_write_latency", 32'(lat), 32'd11);
      for (int i = 1; i < 4; i++)
         req(1'b1, 32'h3800_0000 + 32'(4*i), 4'hF, 32'hA000_0000 + 32'(i), 0, 0, lat, rd);
      for (int i = 0; i < 4; i++) begin
         req(1'b1, 32'h3800_0010 + 32'(4*i), 4'hF, 32'hCAFE_0010 + 32'(4*i), 0, 0, lat, rd);
         req(1'b1, 32'h3800_0040 + 32'(4*i), 4'hF, 32'hB000_0040 + 32'(4*i), 0, 0, lat, rd);
      end
      req(1'b1, 32'h3800_0008, 4'h0, 32'hDEAD_BEEF, 0, 0, lat, rd);

      // Cold miss then sequential hits
      req(1'b0, 32'h3800_0000, 4'hF, 32'd0, 0, 0, lat, rd);
      chk32("t2_miss_latency", 32'(lat), 32'd15);
      chk32("t2_miss_data", rd, 32'h1234_5678);
      chk32("t2_miss_cnt", 32'(miss), 32'd1);
      req(1'b0, 32'h3800_0004, 4'hF, 32'd0, 0, 0, lat, rd);
      chk32("t2_hit_latency", 32'(lat), 32'd1);
      chk32("t2_hit_cnt", 32'(hit), 32'd1);
      req(1'b0, 32'h3800_0008, 4'hF, 32'd0, 0, 0, lat, rd);
      chk32("t2_sel0_nochange", rd, 32'hA000_0002);

      // Byte-lane writes into a valid line
      req(1'b1, 32'h3800_0000, 4'b0001, 32'h0000_00AA, 0, 0, lat, rd);
      req(1'b0, 32'h3800_0000, 4'hF, 32'd0, 0, 0, lat, rd);
      chk32("t3_hit_latency", 32'(lat), 32'd1);
      chk32("t3_merge_data", rd, 32'h1234_56AA);
      req(1'b1, 32'h3800_000C, 4'b0110, 32'h5566_7788, 0, 0, lat, rd);
      req(1'b0, 32'h3800_000D, 4'hF, 32'd0, 0, 0, lat, rd);
      chk32("t3_mid_lanes", rd, 32'hA066_7703);

      // Aborts in FILL and WAIT
      req(1'b0, 32'h3800_0040, 4'hF, 32'd0, 12, 0, lat, rd);
      chk32("t4_abort_noack", 32'(lat), 32'hFFFF_FFFF);
      req(1'b0, 32'h3800_0040, 4'hF, 32'd0, 0, 0, lat, rd);
      chk32("t4_remiss_latency", 32'(lat), 32'd15);
      chk32("t4_miss_cnt", 32'(miss), 32'd2);
      req(1'b1, 32'h3800_0044, 4'hF, 32'h0000_0BAD, 5, 0, lat, rd);
      req(1'b0, 32'h3800_0010, 4'hF, 32'd0, 3, 0, lat, rd);
      req(1'b0, 32'h3800_0044, 4'hF, 32'd0, 0, 0, lat, rd);
      chk32("t4_wait_abort_hit", 32'(lat), 32'd1);
      chk32("t4_uncommitted", rd, 32'hB000_0044);

      // Reset during a write's WAIT
      req(1'b1, 32'h3800_0010, 4'hF, 32'hFFFF_FFFF, 0, 5, lat, rd);
      chk32("t5_reset_noack", 32'(lat), 32'hFFFF_FFFF);
      chk32("t5_hit_cleared", 32'(hit), 32'd0);
      req(1'b0, 32'h3800_0010, 4'hF, 32'd0, 0, 0, lat, rd);
      chk32("t5_miss_after_reset", 32'(lat), 32'd15);
      chk32("t5_prewrite_data", rd, 32'hCAFE_0010);

      // Out-of-window and counter saturation
      req(1'b0, 32'h3000_0000, 4'hF, 32'd0, 0, 0, lat, rd);
      chk32("t6_oow_latency", 32'(lat), 32'd1);
      chk32("t6_oow_data", rd, 32'd0);
      chk32("t6_oow_miss_cnt", 32'(miss), 32'd1);
      req(1'b1, 32'h3900_0014, 4'hF, 32'h7777_7777, 0, 0, lat, rd);
      req(1'b0, 32'h3800_0014, 4'hF, 32'd0, 0, 0, lat, rd);
      chk32("t6_oow_write_ignored", rd, 32'hCAFE_0014);
      @(posedge clk); #1;
      force dut.hit_q = 16'hFFFF;
      m_hit = 16'hFFFF;
      exp_idle();
      @(posedge clk); #1;
      release dut.hit_q;
      req(1'b0, 32'h3800_0018, 4'hF, 32'd0, 0, 0, lat, rd);
      chk32("t6_hit_saturated", 32'(hit), 32'h0000_FFFF);
      chk32("t6_sat_hit_data", rd, 32'hCAFE_0018);

      @(posedge clk); #1;
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
